// File: rtl/sdram_axi_pkg.sv
// Shared definitions for the SDRAM AXI4 path: AXI encodings, widths and the
// APB-to-AXI bridge state encoding.
package sdram_axi_pkg;

    localparam int AXI_LEN_W = 8;
    localparam int AXI_ID_W  = 4;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/sdram_apb2axi.sv
// APB3/APB4 slave to AXI4 single-beat master bridge in front of the SDRAM
// controller; one APB transfer maps to one AXI transaction, one in flight.
module sdram_apb2axi
    import sdram_axi_pkg::*;
#(
    parameter logic [AXI_ID_W-1:0] AXI_ID    = 4'd0,
    parameter logic [31:0]         ADDR_MASK = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] paddr_i,
    input  logic [31:0] pwdata_i,
    input  logic [3:0]  pstrb_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o,

    output logic        outport_awvalid_o,
    input  logic        outport_awready_i,
    output logic [31:0] outport_awaddr_o,
    output logic [3:0]  outport_awid_o,
    output logic [7:0]  outport_awlen_o,
    output logic [1:0]  outport_awburst_o,

    output logic        outport_wvalid_o,
    input  logic        outport_wready_i,
    output logic [31:0] outport_wdata_o,
    output logic [3:0]  outport_wstrb_o,
    output logic        outport_wlast_o,

    input  logic        outport_bvalid_i,
    output logic        outport_bready_o,
    input  logic [1:0]  outport_bresp_i,
    input  logic [3:0]  outport_bid_i,

    output logic        outport_arvalid_o,
    input  logic        outport_arready_i,
    output logic [31:0] outport_araddr_o,
    output logic [3:0]  outport_arid_o,
    output logic [7:0]  outport_arlen_o,
    output logic [1:0]  outport_arburst_o,

    input  logic        outport_rvalid_i,
    output logic        outport_rready_o,
    input  logic [31:0] outport_rdata_i,
    input  logic [1:0]  outport_rresp_i,
    input  logic [3:0]  outport_rid_i,
    input  logic        outport_rlast_i
);

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic        err_q;
    logic [31:0] prdata_q;

    logic accept;
    logic aw_hs;
    logic w_hs;

    // Response IDs are not checked: only one transaction is ever outstanding.
    logic unused_ids;
    assign unused_ids = ^{outport_bid_i, outport_rid_i};

    assign accept = (state_q == IDLE) && psel_i && penable_i;
    assign aw_hs  = outport_awvalid_o && outport_awready_i;
    assign w_hs   = outport_wvalid_o && outport_wready_i;

    // NOTE: every variable in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = pwrite_i ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (outport_bvalid_i) state_d = DONE;
            end
            RD_REQ: begin
                if (outport_arready_i) state_d = RD_RESP;
            end
            RD_RESP: begin
                if (outport_rvalid_i) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, and the
    // reset is synchronous, so it is sampled inside the clocked block.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q <= state_d;

            // Request fields change only here, so they stay stable while valid is high.
            if (accept) begin
                addr_q    <= paddr_i & ADDR_MASK;
                wdata_q   <= pwdata_i;
                wstrb_q   <= pstrb_i;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end

            if (state_q == WR_REQ) begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
            end

            if (state_q == WR_RESP && outport_bvalid_i) begin
                err_q <= (outport_bresp_i != RESP_OKAY);
            end

            if (state_q == RD_RESP && outport_rvalid_i) begin
                prdata_q <= outport_rdata_i;
                err_q    <= (outport_rresp_i != RESP_OKAY) || !outport_rlast_i;
            end
        end
    end

    assign pready_o  = (state_q == DONE);
    assign pslverr_o = (state_q == DONE) && err_q;
    assign prdata_o  = prdata_q;

    // Each write channel drops its valid the cycle after its own handshake.
    assign outport_awvalid_o = (state_q == WR_REQ) && !aw_done_q;
    assign outport_awaddr_o  = addr_q;
    assign outport_awid_o    = AXI_ID;
    assign outport_awlen_o   = '0;
    assign outport_awburst_o = BURST_INCR;

    assign outport_wvalid_o  = (state_q == WR_REQ) && !w_done_q;
    assign outport_wdata_o   = wdata_q;
    assign outport_wstrb_o   = wstrb_q;
    assign outport_wlast_o   = 1'b1;

    assign outport_bready_o  = (state_q == WR_RESP);

    assign outport_arvalid_o = (state_q == RD_REQ);
    assign outport_araddr_o  = addr_q;
    assign outport_arid_o    = AXI_ID;
    assign outport_arlen_o   = '0;
    assign outport_arburst_o = BURST_INCR;

    assign outport_rready_o  = (state_q == RD_RESP);

endmodule

// File: tb/tb_sdram_apb2axi.sv
// Directed bench for sdram_apb2axi: a default-mask instance plus a second
// instance with ADDR_MASK=0x0FFF_FFFF sharing the same stimulus.
module tb_sdram_apb2axi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic        awready, wready, bvalid, arready, rvalid, rlast;
    logic [1:0]  bresp, rresp;
    logic [3:0]  bid, rid;
    logic [31:0] rdata;

    logic        pready, pslverr;
    logic [31:0] prdata;
    logic        awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  awid, wstrb, arid;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst;

    logic        m_pready, m_pslverr;
    logic [31:0] m_prdata;
    logic        m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr;
    logic [3:0]  m_awid, m_wstrb, m_arid;
    logic [7:0]  m_awlen, m_arlen;
    logic [1:0]  m_awburst, m_arburst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_apb2axi dut (
        .clk_i(clk), .rst_ni(rst_n),
        .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .pready_o(pready), .prdata_o(prdata), .pslverr_o(pslverr),
        .outport_awvalid_o(awvalid), .outport_awready_i(awready),
        .outport_awaddr_o(awaddr), .outport_awid_o(awid),
        .outport_awlen_o(awlen), .outport_awburst_o(awburst),
        .outport_wvalid_o(wvalid), .outport_wready_i(wready),
        .outport_wdata_o(wdata), .outport_wstrb_o(wstrb), .outport_wlast_o(wlast),
        .outport_bvalid_i(bvalid), .outport_bready_o(bready),
        .outport_bresp_i(bresp), .outport_bid_i(bid),
        .outport_arvalid_o(arvalid), .outport_arready_i(arready),
        .outport_araddr_o(araddr), .outport_arid_o(arid),
        .outport_arlen_o(arlen), .outport_arburst_o(arburst),
        .outport_rvalid_i(rvalid), .outport_rready_o(rready),
        .outport_rdata_i(rdata), .outport_rresp_i(rresp),
        .outport_rid_i(rid), .outport_rlast_i(rlast)
    );

    sdram_apb2axi #(.AXI_ID(4'd0), .ADDR_MASK(32'h0FFF_FFFF)) dut_mask (
        .clk_i(clk), .rst_ni(rst_n),
        .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .pready_o(m_pready), .prdata_o(m_prdata), .pslverr_o(m_pslverr),
        .outport_awvalid_o(m_awvalid), .outport_awready_i(awready),
        .outport_awaddr_o(m_awaddr), .outport_awid_o(m_awid),
        .outport_awlen_o(m_awlen), .outport_awburst_o(m_awburst),
        .outport_wvalid_o(m_wvalid), .outport_wready_i(wready),
        .outport_wdata_o(m_wdata), .outport_wstrb_o(m_wstrb), .outport_wlast_o(m_wlast),
        .outport_bvalid_i(bvalid), .outport_bready_o(m_bready),
        .outport_bresp_i(bresp), .outport_bid_i(bid),
        .outport_arvalid_o(m_arvalid), .outport_arready_i(arready),
        .outport_araddr_o(m_araddr), .outport_arid_o(m_arid),
        .outport_arlen_o(m_arlen), .outport_arburst_o(m_arburst),
        .outport_rvalid_i(rvalid), .outport_rready_o(m_rready),
        .outport_rdata_i(rdata), .outport_rresp_i(rresp),
        .outport_rid_i(rid), .outport_rlast_i(rlast)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // APB setup then access phase; returns just after the accept edge.
    task automatic apb_start(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        tick();
        penable = 1'b1;
        tick();
    endtask

    task automatic apb_end();
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic axi_idle();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rlast = 1'b1; rdata = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        bid = 4'h7; rid = 4'h9;
        axi_idle();
        tick(); tick();

        // Reset state and constant outputs
        check("rst_pready",  pready,  0);
        check("rst_pslverr", pslverr, 0);
        check("rst_prdata",  prdata,  0);
        check("rst_valids",  {awvalid, wvalid, bready, arvalid, rready}, 0);
        check("const_awlen", awlen, 0);
        check("const_arlen", arlen, 0);
        check("const_awburst", awburst, 2'b01);
        check("const_arburst", arburst, 2'b01);
        check("const_wlast", wlast, 1);
        check("const_ids",   {awid, arid}, 0);
        rst_n = 1'b1;
        tick();

        // Write with AXI always ready: pready at cycle 3
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        apb_start(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        check("w1_c1_valids", {awvalid, wvalid}, 2'b11);
        check("w1_awaddr", awaddr, 32'h8000_0010);
        check("w1_wdata",  wdata,  32'hDEAD_BEEF);
        check("w1_wstrb",  wstrb,  4'hF);
        check("w1_wlast",  wlast,  1);
        check("w1_c1_pready", pready, 0);
        tick();
        check("w1_c2_valids", {awvalid, wvalid}, 2'b00);
        check("w1_c2_bready", bready, 1);
        check("w1_c2_pready", pready, 0);
        tick();
        check("w1_c3_pready",  pready,  1);
        check("w1_c3_pslverr", pslverr, 0);
        apb_end();
        tick();
        check("w1_after_pready", pready, 0);
        axi_idle();

        // Read with arready delayed 4 cycles: arvalid held 5 cycles
        rvalid = 1'b1; rdata = 32'h1234_5678; rlast = 1'b1; rresp = 2'b00;
        apb_start(1'b0, 32'h8000_0020, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("r1_arvalid_%0d", i), arvalid, 1);
            check($sformatf("r1_araddr_%0d", i), araddr, 32'h8000_0020);
            if (i == 4) arready = 1'b1;
            tick();
        end
        arready = 1'b0;
        check("r1_arvalid_drop", arvalid, 0);
        check("r1_rready", rready, 1);
        check("r1_resp_pready", pready, 0);
        tick();
        check("r1_pready",  pready,  1);
        check("r1_prdata",  prdata,  32'h1234_5678);
        check("r1_pslverr", pslverr, 0);
        apb_end();
        tick();
        check("r1_pulse_end", pready, 0);
        check("r1_prdata_hold", prdata, 32'h1234_5678);
        axi_idle();

        // Independent AW / W acceptance
        awready = 1'b1;
        apb_start(1'b1, 32'h8000_0040, 32'h5555_AAAA, 4'hF);
        check("w3_c1_valids", {awvalid, wvalid}, 2'b11);
        tick();
        check("w3_c2_valids", {awvalid, wvalid}, 2'b01);
        check("w3_c2_bready", bready, 0);
        tick();
        check("w3_c3_valids", {awvalid, wvalid}, 2'b01);
        check("w3_c3_wdata", wdata, 32'h5555_AAAA);
        wready = 1'b1;
        tick();
        check("w3_c4_valids", {awvalid, wvalid}, 2'b00);
        check("w3_c4_bready", bready, 1);
        tick();
        check("w3_c5_bready", bready, 1);
        check("w3_c5_pready", pready, 0);
        bvalid = 1'b1;
        tick();
        check("w3_pready",  pready,  1);
        check("w3_pslverr", pslverr, 0);
        apb_end();
        tick();
        axi_idle();

        // Error responses: bresp=SLVERR, then rlast=0 on a read
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
        apb_start(1'b1, 32'h8000_0050, 32'h1, 4'hF);
        tick(); tick();
        check("e1_pready",  pready,  1);
        check("e1_pslverr", pslverr, 1);
        apb_end();
        tick();
        check("e1_pslverr_clear", pslverr, 0);
        axi_idle();
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 2'b00; rlast = 1'b0;
        apb_start(1'b0, 32'h8000_0060, 32'h0, 4'h0);
        tick(); tick();
        check("e2_pready",  pready,  1);
        check("e2_pslverr", pslverr, 1);
        check("e2_prdata",  prdata,  32'hCAFE_F00D);
        apb_end();
        tick();
        axi_idle();

        // Reset during WR_RESP, then a clean read
        awready = 1'b1; wready = 1'b1;
        apb_start(1'b1, 32'h8000_0070, 32'h7777_7777, 4'hF);
        tick();
        check("rs_in_wr_resp", bready, 1);
        rst_n = 1'b0;
        apb_end();
        tick();
        check("rs_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
        check("rs_pready",  pready,  0);
        check("rs_pslverr", pslverr, 0);
        check("rs_prdata",  prdata,  0);
        check("rs_awaddr",  awaddr,  0);
        rst_n = 1'b1;
        axi_idle();
        tick();
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h0BAD_CAFE; rlast = 1'b1;
        apb_start(1'b0, 32'h8000_0080, 32'h0, 4'h0);
        check("rs_rd_arvalid", arvalid, 1);
        tick(); tick();
        check("rs_rd_pready",  pready,  1);
        check("rs_rd_prdata",  prdata,  32'h0BAD_CAFE);
        check("rs_rd_pslverr", pslverr, 0);
        apb_end();
        tick();
        axi_idle();

        // Byte write with masked address on the second instance
        apb_start(1'b1, 32'hA000_0004, 32'h0000_AB00, 4'b0010);
        check("bw_awaddr_nomask", awaddr,   32'hA000_0004);
        check("bw_awaddr_mask",   m_awaddr, 32'h0000_0004);
        check("bw_wstrb_mask",    m_wstrb,  4'b0010);
        check("bw_awvalid_mask",  m_awvalid, 1);
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        tick(); tick();
        check("bw_pready_mask", m_pready, 1);
        apb_end();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_apb2axi.md
Name: sdram_apb2axi

Overview:
APB3/APB4 slave to AXI4 single-beat master bridge, placed directly upstream of the SDRAM AXI4 controller. Lets the APB peripheral fabric reach SDRAM.
Each APB transfer becomes exactly one AXI4 transaction: awlen=0 or arlen=0, INCR burst, 32-bit data. The bridge holds pready low until the AXI response returns.
Only one transaction is outstanding at any time; there is no write buffering.

Parameters:
AXI_ID, 4'd0, constant value driven on awid/arid; returned bid/rid is ignored.
ADDR_MASK, 32'hFFFF_FFFF, ANDed with paddr to form awaddr/araddr.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
psel_i  in  1  APB select
penable_i  in  1  APB access phase
pwrite_i  in  1  1=write
paddr_i  in  32  APB address
pwdata_i  in  32  write data
pstrb_i  in  4  byte strobes
pready_o  out  1  transfer complete
prdata_o  out  32  read data
pslverr_o  out  1  error response
outport_awvalid_o / outport_awready_i  out/in  1  AW handshake
outport_awaddr_o  out  32  write address
outport_awid_o  out  4  write ID
outport_awlen_o  out  8  write burst length
outport_awburst_o  out  2  write burst type
outport_wvalid_o / outport_wready_i  out/in  1  W handshake
outport_wdata_o  out  32  write data
outport_wstrb_o  out  4  write strobes
outport_wlast_o  out  1  last write beat
outport_bvalid_i / outport_bready_o  in/out  1  B handshake
outport_bresp_i  in  2  write response
outport_bid_i  in  4  write response ID
outport_arvalid_o / outport_arready_i  out/in  1  AR handshake
outport_araddr_o  out  32  read address
outport_arid_o  out  4  read ID
outport_arlen_o  out  8  read burst length
outport_arburst_o  out  2  read burst type
outport_rvalid_i / outport_rready_o  in/out  1  R handshake
outport_rdata_i  in  32  read data
outport_rresp_i  in  2  read response
outport_rid_i  in  4  read response ID
outport_rlast_i  in  1  last read beat

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - State goes to IDLE.
  - All valid/ready outputs are 0, and pready_o=0, pslverr_o=0, prdata_o=0.
  - Any in-flight AXI transaction is abandoned without a response.
- Constant outputs: awlen/arlen=8'd0, awburst/arburst=2'b01, wlast=1, awid/arid=AXI_ID.
- Address, data and strobe registers are loaded only at accept and are stable while valid is high.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE:
  - Accept when psel_i & penable_i.
  - Latch addr = paddr_i & ADDR_MASK, pwdata_i, pstrb_i.
  - Go to WR_REQ if pwrite_i, else RD_REQ.
  - The first AXI valid asserts the cycle after accept.
- WR_REQ:
  - awvalid and wvalid assert together and deassert independently.
  - Each drops the cycle after its own handshake (valid & ready). Per-channel "done" flags track this.
  - Leave for WR_RESP when both are done. Simultaneous acceptance in one cycle is legal.
- WR_RESP:
  - bready=1.
  - On bvalid, latch err = (bresp != 2'b00) and go to DONE.
- RD_REQ: arvalid=1 until arready, then go to RD_RESP.
- RD_RESP:
  - rready=1.
  - On rvalid, latch prdata = rdata and err = (rresp != 0) | ~rlast, then go to DONE.
- DONE:
  - pready_o=1 and pslverr_o=err for exactly one cycle, then IDLE.
  - prdata_o holds its value until the next read completes.
  - pready_o is 0 in every other state.
- Minimum latency with all AXI ready/valid immediate: accept at cycle 0, AXI handshake at 1, response at 2, pready at 3.
- psel_i dropping mid-transfer is a master protocol violation. The bridge still completes the AXI transaction and pulses pready; the result is discarded by the master.
- A new accept is not possible in DONE, because the FSM is not in IDLE; back-to-back APB transfers therefore have at least one idle cycle between them.
- No AXI output changes while its valid is high and unaccepted (AXI stability rule).

Decomposition:
- Shared package sdram_axi_pkg holds:
  - BURST_INCR=2'b01 and RESP_OKAY=2'b00;
  - the FSM state enum (3 bits);
  - the AXI_LEN_W=8 and AXI_ID_W=4 widths.
- No sub-module: a single FSM with datapath registers.

Test Plan:
- Write 0x8000_0010 with pwdata 0xDEAD_BEEF and pstrb 4'hF, AXI always ready, bresp=0:
  - awaddr=0x8000_0010, wdata=0xDEAD_BEEF, wlast=1 in the same cycle;
  - pready at cycle 3, pslverr=0.
- Read 0x8000_0020 with rdata=0x1234_5678, rlast=1, and arready delayed 4 cycles:
  - arvalid is held for 5 cycles;
  - prdata=0x1234_5678, pready a single pulse, pslverr=0.
- Write with awready at cycle 1 and wready at cycle 3:
  - awvalid drops after cycle 1 while wvalid is held to cycle 3;
  - bready rises only after both are done; pready one cycle after bvalid.
- bresp=2'b10 on a write, then rresp=0 with rlast=0 on a read:
  - pslverr=1 on both transfers.
- rst_ni low during WR_RESP:
  - all outputs return to 0 next cycle;
  - the following read completes normally with the correct prdata.
- Byte write with pstrb=4'b0010 and ADDR_MASK=32'h0FFF_FFFF, paddr 0xA000_0004:
  - awaddr=0x0000_0004, wstrb=4'b0010.
